// File: rtl/dot_row_feeder_pkg.sv
// Shared constants and state encoding for the dot-product row feeder.
package dot_row_feeder_pkg;

  localparam int NO_OF_UNITS   = 8;
  localparam int ELEMENT_WIDTH = 32;
  localparam int PACKET_W      = NO_OF_UNITS * ELEMENT_WIDTH;
  localparam int LANE_IDX_W    = $clog2(NO_OF_UNITS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    DRIVE,
    WAIT_ROW,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/dot_row_feeder_tail_lane_mask.sv
// Lane mask for a row's final packet: lanes at or beyond the tail count are cleared.
// A tail of zero means the packet is full and every lane is kept.
module tail_lane_mask
  import dot_row_feeder_pkg::*;
(
  input  logic [LANE_IDX_W-1:0] tail,
  output logic [PACKET_W-1:0]   mask
);

  always_comb begin
    mask = '1;
    for (int lane = 0; lane < NO_OF_UNITS; lane++) begin
      // Lane 0 sits in the MSBs of the packet.
      if (tail != '0 && lane >= int'(tail))
        mask[PACKET_W-1-lane*ELEMENT_WIDTH -: ELEMENT_WIDTH] = '0;
    end
  end

endmodule

// File: rtl/dot_row_feeder.sv
// Walks a matrix/vector pair packet by packet for the 8-lane dot-product stage.
// Optional build macro: ZERO_PAD_EN zeroes the unused tail lanes of each row's last packet.
module dot_row_feeder
  import dot_row_feeder_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int PACKET_GAP = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [15:0]         row_count,
  input  logic [15:0]         row_length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   mat_addr,
  output logic [ADDR_W-1:0]   vec_addr,
  output logic                mem_en,
  input  logic [PACKET_W-1:0] mat_rdata,
  input  logic [PACKET_W-1:0] vec_rdata,
  output logic                row_load,
  output logic [31:0]         row_multiples,
  output logic                read_now,
  output logic [PACKET_W-1:0] first_row_out,
  output logic [PACKET_W-1:0] second_row_out,
  input  logic                next_row_ready
);

  feeder_state_t       state, state_next;
  logic [15:0]         rows_q;
  logic [15:0]         row_idx;
  logic [31:0]         pkt_idx;
  logic [3:0]          gap_cnt;
  logic                ready_flag;
  logic [PACKET_W-1:0] mat_hold, vec_hold, mat_pkt, vec_pkt;
  logic                pkt_done, more_pkts, more_rows, row_go;
  logic [31:0]         mat_lin;

  assign pkt_done  = (state == DRIVE) && (gap_cnt == 4'(PACKET_GAP));
  assign more_pkts = (pkt_idx + 32'd1) < row_multiples;
  assign more_rows = ({16'd0, row_idx} + 32'd1) < {16'd0, rows_q};
  assign row_go    = next_row_ready || ready_flag;
  assign mat_lin   = 32'(row_idx) * row_multiples + pkt_idx;

`ifdef ZERO_PAD_EN
  logic [LANE_IDX_W-1:0] tail_q;
  logic [PACKET_W-1:0]   lane_mask;

  tail_lane_mask u_tail_lane_mask (
    .tail (more_pkts ? '0 : tail_q),
    .mask (lane_mask)
  );

  assign mat_pkt = mat_rdata & lane_mask;
  assign vec_pkt = vec_rdata & lane_mask;
`else
  assign mat_pkt = mat_rdata;
  assign vec_pkt = vec_rdata;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = (row_count == '0 || row_length == '0) ? DONE : LOAD;
      LOAD:     state_next = FETCH;
      FETCH:    state_next = DRIVE;
      DRIVE: begin
        if (pkt_done) begin
          if (more_pkts)      state_next = FETCH;
          else if (more_rows) state_next = row_go ? LOAD : WAIT_ROW;
          else                state_next = DONE;
        end
      end
      WAIT_ROW: if (row_go) state_next = LOAD;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = state inside {LOAD, FETCH, DRIVE, WAIT_ROW};
    done     = (state == DONE);
    row_load = (state == LOAD);
    mem_en   = (state == FETCH);
    read_now = (state == DRIVE) && (gap_cnt == '0);
    mat_addr = mem_en ? mat_lin[ADDR_W-1:0] : '0;
    vec_addr = mem_en ? pkt_idx[ADDR_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_q        <= '0;
      row_multiples <= '0;
      row_idx       <= '0;
      pkt_idx       <= '0;
      gap_cnt       <= '0;
      ready_flag    <= 1'b0;
      mat_hold      <= '0;
      vec_hold      <= '0;
`ifdef ZERO_PAD_EN
      tail_q        <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        rows_q        <= row_count;
        row_multiples <= (32'(row_length) + 32'd7) >> 3;
        row_idx       <= '0;
`ifdef ZERO_PAD_EN
        tail_q        <= row_length[LANE_IDX_W-1:0];
`endif
      end
      if (state == LOAD)  pkt_idx <= '0;
      else if (pkt_done)  pkt_idx <= pkt_idx + 32'd1;
      if (state != IDLE && state_next == LOAD) row_idx <= row_idx + 16'd1;
      gap_cnt <= (state == DRIVE && !pkt_done) ? gap_cnt + 4'd1 : '0;
      if (read_now) begin
        mat_hold <= mat_pkt;
        vec_hold <= vec_pkt;
      end
      // An early next-row indication is remembered until the row boundary consumes it.
      if (state inside {DRIVE, WAIT_ROW} && state_next == LOAD) ready_flag <= 1'b0;
      else if (next_row_ready && state != WAIT_ROW)             ready_flag <= 1'b1;
    end
  end

  // Memory data arrives in the strobe cycle itself, so it is passed through then and held after.
  assign first_row_out  = read_now ? mat_pkt : mat_hold;
  assign second_row_out = read_now ? vec_pkt : vec_hold;

endmodule

// File: tb/tb_dot_row_feeder.sv
// Randomized self-checking bench for dot_row_feeder against an event-level row/packet schedule model.
module tb_dot_row_feeder;

  localparam int AW    = 13;
  localparam int GAP   = 2;
  localparam int PER   = 2 + GAP;
  localparam int PW    = 256;
  localparam int DEPTH = 8192;

  logic          clk = 1'b0;
  logic          reset, start, next_row_ready;
  logic [15:0]   row_count, row_length;
  logic          busy, done, mem_en, row_load, read_now;
  logic [AW-1:0] mat_addr, vec_addr;
  logic [PW-1:0] mat_rdata, vec_rdata, first_row_out, second_row_out;
  logic [31:0]   row_multiples;

  always #5 clk = ~clk;

  dot_row_feeder #(.ADDR_W(AW), .PACKET_GAP(GAP)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .row_count      (row_count),
    .row_length     (row_length),
    .busy           (busy),
    .done           (done),
    .mat_addr       (mat_addr),
    .vec_addr       (vec_addr),
    .mem_en         (mem_en),
    .mat_rdata      (mat_rdata),
    .vec_rdata      (vec_rdata),
    .row_load       (row_load),
    .row_multiples  (row_multiples),
    .read_now       (read_now),
    .first_row_out  (first_row_out),
    .second_row_out (second_row_out),
    .next_row_ready (next_row_ready)
  );

  logic [PW-1:0] mat_mem [DEPTH];
  logic [PW-1:0] vec_mem [DEPTH];

  always @(posedge clk) begin
    if (mem_en) begin
      mat_rdata <= mat_mem[mat_addr];
      vec_rdata <= vec_mem[vec_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int            cyc;
    logic [PW-1:0] a;
    logic [PW-1:0] b;
  } ev_t;
  typedef ev_t ev_q_t[$];

  ev_q_t exp_load, got_load, exp_mem, got_mem, exp_rd, got_rd;
  int    exp_done, got_done;

`ifdef ZERO_PAD_EN
  function automatic logic [PW-1:0] lane_zero(input logic [PW-1:0] pkt, input int keep);
    logic [PW-1:0] r;
    r = pkt;
    for (int l = keep; l < 8; l++) r[PW-1-32*l -: 32] = '0;
    return r;
  endfunction
`endif

  // Schedule model, cycles relative to the start cycle (0): each row loads, then every packet
  // takes PER cycles; a row resumes once it has drained and the consumer's ready has arrived.
  task automatic build_expected(input int rows, input int len, input int delay);
    int m, ld, e, rdy, addr;
    logic [PW-1:0] fd, sd;
    exp_load = {};
    exp_mem  = {};
    exp_rd   = {};
    if (rows == 0 || len == 0) begin
      exp_done = 1;
      return;
    end
    m  = (len + 7) / 8;
    ld = 1;
    for (int r = 0; r < rows; r++) begin
      exp_load.push_back('{cyc: ld, a: PW'(m), b: '0});
      for (int p = 0; p < m; p++) begin
        addr = (r * m + p) % DEPTH;
        exp_mem.push_back('{cyc: ld + 1 + PER * p, a: PW'(addr), b: PW'(p % DEPTH)});
        fd = mat_mem[addr];
        sd = vec_mem[p % DEPTH];
`ifdef ZERO_PAD_EN
        if (p == m - 1 && len % 8 != 0) begin
          fd = lane_zero(fd, len % 8);
          sd = lane_zero(sd, len % 8);
        end
`endif
        exp_rd.push_back('{cyc: ld + 2 + PER * p, a: fd, b: sd});
      end
      e = ld + PER * m;
      if (r == rows - 1) exp_done = e + 1;
      else begin
        rdy = ld + 2 + PER * (m - 1) + delay;
        ld  = (rdy <= e) ? e + 1 : rdy + 1;
      end
    end
  endtask

  task automatic compare_q(input string tag, input ev_q_t g, input ev_q_t e);
    int n;
    check({tag, "_count"}, PW'(g.size()), PW'(e.size()));
    n = (g.size() < e.size()) ? g.size() : e.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_cycle"}, PW'(g[i].cyc), PW'(e[i].cyc));
      check({tag, "_a"}, g[i].a, e[i].a);
      check({tag, "_b"}, g[i].b, e[i].b);
    end
  endtask

  // Runs one job cycle by cycle, driving next_row_ready 'delay' cycles after each row's last strobe.
  task automatic run_job(input int rows, input int len, input int delay, input int extra_start_at);
    int m, ready_at, rd_cnt, row_i, hold, busy_bad, limit;
    logic [PW-1:0] ha, hb;
    m = (len + 7) / 8;
    ready_at = -1; rd_cnt = 0; row_i = 0; hold = 0; busy_bad = 0;
    ha = '0; hb = '0;
    build_expected(rows, len, delay);
    got_load = {}; got_mem = {}; got_rd = {}; got_done = -1;
    limit = exp_done + 40;
    @(negedge clk);
    start = 1'b1; row_count = 16'(rows); row_length = 16'(len); next_row_ready = 1'b0;
    for (int t = 1; t <= limit; t++) begin
      @(negedge clk);
      start = (t == extra_start_at);
      if (start) begin
        row_count  = 16'd5;
        row_length = 16'd64;
      end
      if (busy !== (t < exp_done)) busy_bad++;
      if (row_load) got_load.push_back('{cyc: t, a: PW'(row_multiples), b: '0});
      if (mem_en)   got_mem.push_back('{cyc: t, a: PW'(mat_addr), b: PW'(vec_addr)});
      if (read_now) begin
        check("strobe_spacing", PW'(hold), PW'(0));
        got_rd.push_back('{cyc: t, a: first_row_out, b: second_row_out});
        ha = first_row_out; hb = second_row_out; hold = GAP;
        rd_cnt++;
        if (rd_cnt == m) begin
          rd_cnt = 0;
          row_i++;
          if (row_i < rows) ready_at = t + delay;
        end
      end else if (hold > 0) begin
        check("hold_first", first_row_out, ha);
        check("hold_second", second_row_out, hb);
        hold--;
      end
      next_row_ready = (t == ready_at);
      if (done && got_done < 0) got_done = t;
      if (got_done >= 0 && t >= got_done + 3) break;
    end
    next_row_ready = 1'b0;
    check("done_cycle", PW'(got_done), PW'(exp_done));
    check("busy_window", PW'(busy_bad), PW'(0));
    compare_q("row_load", got_load, exp_load);
    compare_q("fetch", got_mem, exp_mem);
    compare_q("read_now", got_rd, exp_rd);
  endtask

  initial begin
    int rows, m, len, seen;
    reset = 1'b1; start = 1'b0; next_row_ready = 1'b0; row_count = '0; row_length = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int w = 0; w < 8; w++) begin
        mat_mem[i][32*w +: 32] = $urandom;
        vec_mem[i][32*w +: 32] = $urandom;
      end
    repeat (3) @(negedge clk);
    check("reset_ctrl", PW'({busy, done, row_load, read_now, mem_en, mat_addr, vec_addr, row_multiples}), '0);
    check("reset_first", first_row_out, '0);
    check("reset_second", second_row_out, '0);
    reset = 1'b0;

    mat_mem[0] = {8{32'h3f80_0000}};
    vec_mem[0] = {8{32'h4000_0000}};
    run_job(1, 8, 0, -1);
    run_job(3, 16, 10, 4);

    for (int i = 0; i < 4; i++) begin
      mat_mem[i] = '1;
      vec_mem[i] = '1;
    end
    run_job(2, 11, 5, -1);

    run_job(3, 24, 1, -1);
    run_job(2, 8, GAP, -1);
    run_job(3, 8, 0, -1);
    run_job(0, 8, 0, -1);
    run_job(2, 0, 0, -1);

    // Reset during the second packet of a four-packet row.
    @(negedge clk);
    start = 1'b1; row_count = 16'd1; row_length = 16'd32;
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_reset_strobe", PW'(read_now), PW'(1));
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_ctrl", PW'({busy, done, row_load, read_now, mem_en, mat_addr, vec_addr, row_multiples}), '0);
    check("mid_reset_first", first_row_out, '0);
    check("mid_reset_second", second_row_out, '0);
    reset = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("mid_reset_quiet", PW'(seen), PW'(0));
    run_job(1, 32, 0, -1);

    for (int k = 0; k < 6; k++) begin
      rows = $urandom_range(1, 4);
      m    = $urandom_range(1, 6);
`ifdef ZERO_PAD_EN
      len  = $urandom_range(8 * m - 7, 8 * m);
`else
      len  = 8 * m;
`endif
      run_job(rows, len, $urandom_range(0, 12), -1);
    end

    run_job(3, 8 * 2800, 3, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dot_row_feeder.md
# dot_row_feeder

Upstream feeder for the 8-lane dot-product stage. Walks a dense matrix and a vector held in two packet-wide (NO_OF_UNITS × ELEMENT_WIDTH) single-port memories and emits, per matrix row, a row-load pulse carrying the packet count followed by one read-now strobe per 8-element packet pair. Rows are paced by the consumer's next-row indication so the dot-product stage never sees a new row before it has drained the previous one.

## Interface
- NO_OF_UNITS, 8, lanes per packet
- ELEMENT_WIDTH, 32, bits per element (IEEE-754 single)
- ADDR_W, 13, packet address width of both memories
- PACKET_GAP, 2, cycles each packet is held after its strobe (consumer takes one half per cycle); legal 2..15
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, begins a job when idle
- row_count  in  16  rows in job
- row_length  in  16  elements per row
- busy  out  1  job in progress
- done  out  1  one-cycle pulse, job finished
- mat_addr / vec_addr  out  ADDR_W  packet addresses
- mem_en  out  1  read enable, both memories (1-cycle read latency)
- mat_rdata / vec_rdata  in  NO_OF_UNITS*ELEMENT_WIDTH  memory data
- row_load  out  1  one-cycle pulse, row_multiples valid (drives consumer's per-row reset/FIFO push)
- row_multiples  out  32  ceil(row_length/NO_OF_UNITS)
- read_now  out  1  one-cycle pulse, packet valid
- first_row_out / second_row_out  out  NO_OF_UNITS*ELEMENT_WIDTH  matrix / vector packet, lane 0 in MSBs
- next_row_ready  in  1  pulse from consumer, previous row fully taken

## Operation
- States: IDLE, LOAD, FETCH, DRIVE, WAIT_ROW, DONE.
- IDLE: start with row_count≥1 and row_length≥1 → LOAD; busy=1. Start with either zero → DONE directly (done pulse, no row_load). Start while busy ignored.
- LOAD: row_load=1 one cycle; row_multiples = (row_length+7)>>3; packet index j=0 → FETCH.
- FETCH: mem_en=1, mat_addr = r*row_multiples + j, vec_addr = j (mod 2^ADDR_W, wrap silently) → DRIVE.
- DRIVE: first cycle registers rdata to outputs, read_now=1; data held PACKET_GAP further cycles. Then j+1<multiples → FETCH; else r+1<row_count → WAIT_ROW; else DONE.
- WAIT_ROW: next_row_ready → r+1, LOAD. A next_row_ready arriving in any other state is latched in a 1-bit sticky flag and consumed on WAIT_ROW entry (zero-cycle stay).
- DONE: done=1 one cycle, busy=0 → IDLE.
- Last packet of a row with row_length%8≠0: lanes ≥ row_length%8 handled per Configuration.
- Address products computed at 32 bits, truncated to ADDR_W.

## Timing
- Reset values: busy=0, done=0, row_load=0, read_now=0, mem_en=0, addresses=0, row_multiples=0, data outputs=0, sticky flag=0.
- start at cycle 0 → row_load cycle 1, mem_en cycle 2, read_now cycle 3.
- Packet period = 2 + PACKET_GAP cycles (4 at default).
- Data outputs stable from read_now cycle through PACKET_GAP following cycles.
- reset mid-job: next cycle IDLE, all outputs at reset values; no done pulse.

## Configuration
- ZERO_PAD_EN defined: tail lanes of a row's last packet forced to 0 on both outputs (contributes +0.0 to sum).
- Undefined: no masking; row_length must be a multiple of NO_OF_UNITS, data passed as read; tail lanes carry memory contents.

## Structure
- Shared package: NO_OF_UNITS, ELEMENT_WIDTH, packet width constant, feeder state enum.
- One sub-module: tail_lane_mask (row_length%8 → NO_OF_UNITS*ELEMENT_WIDTH mask), instantiated only under ZERO_PAD_EN.

## Test plan
- row_count=1, row_length=8, mat[0]=1.0×8, vec[0]=2.0×8 → row_load cycle 1 with multiples=1, read_now cycle 3 with those packets, done cycle 6.
- row_count=3, row_length=16, next_row_ready pulsed 10 cycles after each row's last packet → mat_addr sequence 0,1 | 2,3 | 4,5, vec_addr 0,1 per row, three row_load pulses, no LOAD before ready.
- row_length=11 with ZERO_PAD_EN, all-ones memory → second packet lanes 3..7 = 0, lanes 0..2 unchanged; without macro, lanes unmasked.
- next_row_ready pulsed during DRIVE of the row's last packet → WAIT_ROW lasts zero cycles, next row_load immediately follows.
- row_count=0 → done one cycle after start, no row_load, no mem_en; start pulsed while busy → ignored.
- reset asserted in DRIVE of packet 2 of 4 → all outputs zero next cycle; new start replays from mat_addr 0.
